// File: rtl/fma_dot_seq.sv
// Dot-product sequencer feeding a combinational FMA: acc = init + sum(a[i] * b[i]).
// Optional build macro FMA_DOT_ZERO_BYPASS_EN skips terms with a zero/denormal operand.
module fma_dot_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      init_fp,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_fp,
    input  logic [31:0]      b_fp,
    output logic [31:0]      fma_a,
    output logic [31:0]      fma_b,
    output logic [31:0]      fma_c,
    input  logic [31:0]      fma_out,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result_fp,
    output logic             result_valid
);

    typedef enum logic [1:0] {StIdle, StLoad, StMac, StDone} state_e;

    state_e           state_q;
    logic [31:0]      acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_dec;
    logic [31:0]      mac_acc;

    assign cnt_dec = cnt_q - LEN_W'(1);

`ifdef FMA_DOT_ZERO_BYPASS_EN
    logic skip_q;
    logic skip_d;

    // The FMA forces the hidden bit, so zero/denormal operands must not reach the accumulator.
    assign skip_d  = (a_fp[30:23] == 8'd0) || (b_fp[30:23] == 8'd0);
    assign mac_acc = skip_q ? acc_q : fma_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= 1'b0;
        end else if (state_q == StLoad && in_valid) begin
            skip_q <= skip_d;
        end
    end
`else
    assign mac_acc = fma_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= 32'h0;
            cnt_q        <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result_fp    <= 32'h0;
            fma_a        <= 32'h0;
            fma_b        <= 32'h0;
            fma_c        <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q <= init_fp;
                        cnt_q <= len;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state_q      <= StDone;
                            done         <= 1'b1;
                            result_fp    <= init_fp;
                            result_valid <= 1'b1;
                        end else begin
                            state_q      <= StLoad;
                            in_ready     <= 1'b1;
                            result_valid <= 1'b0;
                        end
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        fma_a    <= a_fp;
                        fma_b    <= b_fp;
                        fma_c    <= acc_q;
                        in_ready <= 1'b0;
                        state_q  <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= mac_acc;
                    cnt_q <= cnt_dec;
                    // Result is published on entry to DONE so it is valid alongside the pulse.
                    if (cnt_dec == '0) begin
                        state_q      <= StDone;
                        done         <= 1'b1;
                        result_fp    <= mac_acc;
                        result_valid <= 1'b1;
                    end else begin
                        state_q  <= StLoad;
                        in_ready <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fma_dot_seq.sv
// Self-checking bench for fma_dot_seq; a wrapping integer a*b+c stands in for the FMA.
// Honours FMA_DOT_ZERO_BYPASS_EN in its reference model when the macro is defined.
module tb_fma_dot_seq;

    localparam int LEN_W = 8;
`ifdef FMA_DOT_ZERO_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      init_fp;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a_fp, b_fp;
    logic [31:0]      fma_a, fma_b, fma_c, fma_out;
    logic             busy, done, result_valid;
    logic [31:0]      result_fp;

    int errors = 0;
    int checks = 0;

    logic [31:0] pa [0:15];
    logic [31:0] pb [0:15];
    logic [31:0] exp_a, exp_b, exp_c;

    fma_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .init_fp(init_fp),
        .in_valid(in_valid), .in_ready(in_ready), .a_fp(a_fp), .b_fp(b_fp),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_out(fma_out),
        .busy(busy), .done(done), .result_fp(result_fp), .result_valid(result_valid)
    );

    assign fma_out = fma_a * fma_b + fma_c;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit skip_term(input logic [31:0] a, input logic [31:0] b);
        return BypassEn && ((a[30:23] == 8'd0) || (b[30:23] == 8'd0));
    endfunction

    // Accumulator after the first k terms.
    function automatic logic [31:0] model(input int k, input logic [31:0] init);
        logic [31:0] acc;
        acc = init;
        for (int i = 0; i < k; i++)
            if (!skip_term(pa[i], pb[i])) acc = acc + pa[i] * pb[i];
        return acc;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_result_valid"}, {31'h0, result_valid}, 32'h0);
        chk({tag, "_result_fp"}, result_fp, 32'h0);
        chk({tag, "_fma_a"}, fma_a, 32'h0);
        chk({tag, "_fma_b"}, fma_b, 32'h0);
        chk({tag, "_fma_c"}, fma_c, 32'h0);
    endtask

    task automatic run_op(input string tag, input int n, input logic [31:0] init,
                          input int gap, input int poke, input bit start_at_done);
        int cyc, done_cyc, macs, taken, g;
        bit busy_ok;
        start = 1'b1; len = LEN_W'(n); init_fp = init; in_valid = 1'b0;
        step();
        start = 1'b0;
        cyc = 1; done_cyc = -1; macs = 0; taken = 0; g = 0; busy_ok = 1'b1;
        while (cyc < 400 && done_cyc < 0) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (cyc == poke) begin
                    start = 1'b1; len = LEN_W'(5); init_fp = ~init;
                end else begin
                    start = 1'b0;
                end
                if (in_ready === 1'b1) begin
                    if (g < gap || taken >= 16) begin
                        in_valid = 1'b0; g++;
                    end else begin
                        in_valid = 1'b1; a_fp = pa[taken]; b_fp = pb[taken];
                        g = 0; taken++;
                    end
                end else begin
                    in_valid = 1'b0;
                    if (macs < 16) begin
                        chk({tag, "_mac_fma_a"}, fma_a, pa[macs]);
                        chk({tag, "_mac_fma_b"}, fma_b, pb[macs]);
                        chk({tag, "_mac_fma_c"}, fma_c, model(macs, init));
                    end
                    macs++;
                end
                step();
                cyc++;
            end
        end
        in_valid = 1'b0;
        start = start_at_done;
        if (n > 0) begin
            exp_a = pa[n-1]; exp_b = pb[n-1]; exp_c = model(n - 1, init);
        end
        chk({tag, "_done_cycle"}, done_cyc, n * (gap + 2) + 1);
        chk({tag, "_result_fp"}, result_fp, model(n, init));
        chk({tag, "_result_valid"}, {31'h0, result_valid}, 32'h1);
        chk({tag, "_mac_cycles"}, macs, n);
        chk({tag, "_busy_held"}, {31'h0, busy_ok}, 32'h1);
        chk({tag, "_hold_fma_a"}, fma_a, exp_a);
        chk({tag, "_hold_fma_b"}, fma_b, exp_b);
        chk({tag, "_hold_fma_c"}, fma_c, exp_c);
        step();
        start = 1'b0;
        chk({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_idle_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_idle_result_valid"}, {31'h0, result_valid}, 32'h1);
        chk({tag, "_idle_result_fp"}, result_fp, model(n, init));
        if (done_cyc < 0) begin
            rst = 1'b1; step(); rst = 1'b0;
            exp_a = 32'h0; exp_b = 32'h0; exp_c = 32'h0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; init_fp = 32'h0; in_valid = 1'b0;
        a_fp = 32'h0; b_fp = 32'h0;
        exp_a = 32'h0; exp_b = 32'h0; exp_c = 32'h0;
        step();
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;

        run_op("len0", 0, 32'h3F80_0000, 0, -1, 1'b0);

        pa[0] = 32'h4000_0000; pb[0] = 32'h4040_0000;
        pa[1] = 32'h3F80_0000; pb[1] = 32'h3F80_0000;
        run_op("len2", 2, 32'h3F80_0000, 0, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
        run_op("backpressure", 3, $urandom, 4, -1, 1'b0);

        for (int i = 0; i < 2; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
        run_op("ignored_start", 2, $urandom, 0, 3, 1'b1);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
            run_op("random", n, $urandom, int'($urandom_range(2, 0)), -1, 1'b0);
        end

        pa[0] = 32'h4000_0000; pb[0] = 32'h4040_0000;
        pa[1] = 32'h0000_0000; pb[1] = $urandom;
        run_op("zero_operand", 2, 32'h3F80_0000, 0, -1, 1'b0);

        run_op("len0_hold", 0, $urandom, 0, -1, 1'b0);

        start = 1'b1; len = LEN_W'(3); init_fp = $urandom;
        step();
        start = 1'b0; in_valid = 1'b1; a_fp = $urandom; b_fp = $urandom;
        step();
        in_valid = 1'b0;
        chk("midop_in_mac", {31'h0, in_ready}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("midop_reset");
        exp_a = 32'h0; exp_b = 32'h0; exp_c = 32'h0;
        pa[0] = $urandom; pb[0] = $urandom;
        run_op("after_reset", 1, $urandom, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fma_dot_seq.md
# fma_dot_seq

Sequencer that drives the combinational single-precision FMA to compute a dot product: acc = init + Σ a[i]·b[i]. It accepts operand pairs over a valid/ready stream, registers each pair together with the running accumulator onto the FMA's a/b/c inputs, and captures the FMA result back into the accumulator. It sits directly upstream of the FMA, and its accumulator register also consumes the FMA output.

## Interface
- `LEN_W`, default 8: width of the term-count input and the internal down-counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `len` in LEN_W: number of terms; sampled with `start`.
- `init_fp` in 32: initial accumulator value; sampled with `start`.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer accepts a pair this cycle.
- `a_fp`, `b_fp` in 32 each: operand pair.
- `fma_a`, `fma_b`, `fma_c` out 32 each: registered FMA operands.
- `fma_out` in 32: FMA result (combinational from `fma_a`, `fma_b`, `fma_c`).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the result is final.
- `result_fp` out 32: final accumulator value.
- `result_valid` out 1: high from `done` until the next accepted `start`.

## Operation
- States:
  - IDLE: `busy=0`. On `start`: acc←init_fp, cnt←len. Go to DONE if len==0, else to LOAD. `result_valid` clears when `start` is accepted.
  - LOAD: `in_ready=1`. On `in_valid`: fma_a←a_fp, fma_b←b_fp, fma_c←acc, then go to MAC.
  - MAC: `in_ready=0`. acc←fma_out, cnt←cnt−1. Go to DONE if the new cnt==0, else to LOAD.
  - DONE: `done=1`, result_fp←acc, `result_valid` is set, then go to IDLE.
- `start` outside IDLE is ignored; len and init_fp are not re-sampled.
- `in_ready` is a pure function of state (high only in LOAD) and does not depend on `in_valid`.
- `fma_a`, `fma_b`, `fma_c` hold their last values outside MAC; they are not cleared between operations.
- Signs, exponents and NaN/Inf are not interpreted; all 32-bit words pass through untouched (except under the Configuration bypass).
- The counter is unsigned LEN_W bits. The maximum number of terms is 2^LEN_W−1. There is no wrap, because len==0 takes the DONE path.

## Timing
- Reset: state=IDLE, acc=0, cnt=0. `in_ready`, `busy`, `done`, `result_valid` = 0. `result_fp`, `fma_a`, `fma_b`, `fma_c` = 0x00000000.
- `rst` has priority over every other input. Reset mid-operation abandons it; no `done` is produced.
- Throughput is one term per 2 cycles (handshake cycle + MAC cycle).
- Worked example, `start` accepted in cycle 0, `in_valid` held high:
  - LOAD in cycle 1; handshakes in cycles 1, 3, …, 2N−1.
  - MAC in cycles 2, 4, …, 2N.
  - `done` high in cycle 2N+1; IDLE in cycle 2N+2.
- A stalled `in_valid` extends LOAD without limit; no timeout.
- len==0: `done` in cycle 1, `result_fp`=init_fp, and no FMA operand update.
- `start` in the same cycle as `done` is ignored: the state is DONE, not IDLE.

## Configuration
- `FMA_DOT_ZERO_BYPASS_EN`:
  - Defined: in LOAD, the sequencer records a skip flag when a_fp[30:23]==0 or b_fp[30:23]==0 (zero/denormal operand). In MAC with the flag set, acc is unchanged, because the FMA forces the hidden bit and would mis-handle these operands. cnt still decrements and cycle timing is identical.
  - Undefined: no flag; every MAC cycle captures fma_out.

## Test plan
- Reset mid-operation: assert `rst` in a MAC cycle → next cycle all outputs hold their reset values. A new `start` with len=1 then completes normally.
- len=0, init_fp=0x3F800000 → `done` in cycle 1, `result_fp`=0x3F800000, `result_valid`=1, `in_ready` never high.
- len=2, init_fp=0x3F800000, pairs (0x40000000, 0x40400000) then (0x3F800000, 0x3F800000) with `in_valid` held high:
  - In cycle 2: `fma_a`=0x40000000, `fma_b`=0x40400000, `fma_c`=0x3F800000.
  - In cycle 4: `fma_c` equals the `fma_out` sampled in cycle 2.
  - `done` in cycle 5 with `result_fp` equal to the `fma_out` sampled in cycle 4.
- Backpressure: len=3, `in_valid` low for 4 cycles before each pair → `in_ready` stays high throughout each gap; exactly 3 MAC cycles; `done` in cycle 3·(4+2)+1+… per the state trace; `busy` high throughout.
- Ignored start: pulse `start` with len=5 during a len=2 operation → completion after 2 terms with the original init_fp.
- With `FMA_DOT_ZERO_BYPASS_EN`: len=2, second pair a_fp=0x00000000 → acc after term 2 equals acc after term 1; same cycle count as the non-bypass run.
